// File: rtl/sfx_pkg.sv
// Shared types and defaults for the HeadSoccer sound-effect player.
package sfx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

  localparam int unsigned SFX_ADDR_W      = 16;
  localparam int unsigned SFX_DATA_W      = 16;
  localparam int unsigned SFX_REPEAT      = 6;
  localparam int unsigned SFX_GAIN_SHIFT  = 14;
  localparam int unsigned SFX_ROM_LATENCY = 1;

  // Clip bounds inside the effects ROM image (inclusive).
  localparam logic [SFX_ADDR_W-1:0] KICK_START    = 16'd0;
  localparam logic [SFX_ADDR_W-1:0] KICK_END      = 16'd1599;
  localparam logic [SFX_ADDR_W-1:0] GOAL_START    = 16'd1600;
  localparam logic [SFX_ADDR_W-1:0] GOAL_END      = 16'd9599;
  localparam logic [SFX_ADDR_W-1:0] WHISTLE_START = 16'd9600;
  localparam logic [SFX_ADDR_W-1:0] WHISTLE_END   = 16'd13599;

endpackage

// File: rtl/sfx_rom_pipe.sv
// Valid/tag delay line matching the ROM read latency; tag 1 marks the
// initial load read, tag 0 a prefetch read.
module sfx_rom_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic issue,
  input  logic issue_tag,
  output logic out_valid,
  output logic out_tag
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] tag_q, tag_d;

  always_comb begin
    valid_d    = flush ? '0 : (valid_q << 1);
    tag_d      = tag_q << 1;
    valid_d[0] = issue;
    tag_d[0]   = issue_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/sfx_sample_player.sv
// Sound-effect clip player: reads ROM samples, repeats each REPEAT times and
// feeds the Audio_Controller output FIFO; writes silence while idle.
module sfx_sample_player
  import sfx_pkg::*;
#(
  parameter int unsigned ADDR_W      = SFX_ADDR_W,
  parameter int unsigned DATA_W      = SFX_DATA_W,
  parameter int unsigned REPEAT      = SFX_REPEAT,
  parameter int unsigned ROM_LATENCY = SFX_ROM_LATENCY,
  parameter int unsigned GAIN_SHIFT  = SFX_GAIN_SHIFT
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] clip_start,
  input  logic [ADDR_W-1:0] clip_end,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              busy,
  output logic              done
);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         start_q, start_d;
  logic [ADDR_W-1:0]         end_q, end_d;
  logic                      loop_q, loop_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         rom_address_q, rom_address_d;
  logic signed [DATA_W-1:0]  cur_q, cur_d;
  logic                      cur_valid_q, cur_valid_d;
  logic [DATA_W-1:0]         next_q, next_d;
  logic                      next_valid_q, next_valid_d;
  logic [7:0]                rep_q, rep_d;

  logic                      pipe_flush, pipe_issue, pipe_issue_tag;
  logic                      cap_valid, cap_tag;
  logic                      play_ok, last_rep, at_end, pf_hit, next_avail;
  logic [DATA_W-1:0]         next_eff;
  logic [31:0]               sample_ext, sample_scaled;

  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a,
                                            input logic [ADDR_W-1:0] s,
                                            input logic [ADDR_W-1:0] e);
    return (a == e) ? s : a + ADDR_W'(1);
  endfunction

  sfx_rom_pipe #(.LATENCY(ROM_LATENCY)) u_rom_pipe (
    .clk       (CLOCK_50),
    .rst       (reset),
    .flush     (pipe_flush),
    .issue     (pipe_issue),
    .issue_tag (pipe_issue_tag),
    .out_valid (cap_valid),
    .out_tag   (cap_tag)
  );

  assign play_ok    = play && !stop && (clip_end >= clip_start);
  assign last_rep   = (rep_q == 8'(REPEAT - 1));
  assign at_end     = (addr_q == end_q);
  assign pf_hit     = cap_valid && !cap_tag;
  // A prefetch landing on the same edge as the sample advance is used directly.
  assign next_avail = next_valid_q || pf_hit;
  assign next_eff   = next_valid_q ? next_q : rom_data;

  assign sample_ext    = 32'(cur_q);
  assign sample_scaled = sample_ext << GAIN_SHIFT;

  always_comb begin
    write_audio_out = audio_out_allowed && !reset &&
                      (state_q == IDLE || (state_q == PLAY && cur_valid_q));
    done = write_audio_out && state_q == PLAY && last_rep && at_end &&
           !loop_q && !stop && !play_ok;
    left_channel_audio_out  = (state_q == PLAY && cur_valid_q) ? sample_scaled : '0;
    right_channel_audio_out = left_channel_audio_out;
    busy        = (state_q != IDLE);
    rom_address = rom_address_q;
  end

  always_comb begin
    state_d        = state_q;
    start_d        = start_q;
    end_d          = end_q;
    loop_d         = loop_q;
    addr_d         = addr_q;
    rom_address_d  = rom_address_q;
    cur_d          = cur_q;
    cur_valid_d    = cur_valid_q;
    next_d         = next_q;
    next_valid_d   = next_valid_q;
    rep_d          = rep_q;
    pipe_flush     = 1'b0;
    pipe_issue     = 1'b0;
    pipe_issue_tag = 1'b0;

    if (stop) begin
      if (state_q != IDLE) begin
        state_d      = IDLE;
        pipe_flush   = 1'b1;
        cur_valid_d  = 1'b0;
        next_valid_d = 1'b0;
        rep_d        = '0;
      end
    end else if (play_ok) begin
      start_d        = clip_start;
      end_d          = clip_end;
      loop_d         = loop;
      addr_d         = clip_start;
      rom_address_d  = clip_start;
      pipe_flush     = 1'b1;
      pipe_issue     = 1'b1;
      pipe_issue_tag = 1'b1;
      cur_valid_d    = 1'b0;
      next_valid_d   = 1'b0;
      rep_d          = '0;
      state_d        = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (cap_valid && cap_tag) begin
            cur_d         = rom_data;
            cur_valid_d   = 1'b1;
            rep_d         = '0;
            rom_address_d = nxt(addr_q, start_q, end_q);
            pipe_issue    = 1'b1;
            state_d       = PLAY;
          end
        end
        PLAY: begin
          if (pf_hit) begin
            next_d       = rom_data;
            next_valid_d = 1'b1;
          end
          if (!cur_valid_q) begin
            // Recover from a late prefetch once it has arrived.
            if (next_valid_q) begin
              cur_d         = next_q;
              cur_valid_d   = 1'b1;
              next_valid_d  = 1'b0;
              addr_d        = nxt(addr_q, start_q, end_q);
              rom_address_d = nxt(nxt(addr_q, start_q, end_q), start_q, end_q);
              pipe_issue    = 1'b1;
            end
          end else if (write_audio_out) begin
            if (last_rep) begin
              rep_d = '0;
              if (at_end && !loop_q) begin
                state_d      = IDLE;
                cur_valid_d  = 1'b0;
                next_valid_d = 1'b0;
                pipe_flush   = 1'b1;
              end else if (next_avail) begin
                cur_d         = next_eff;
                next_valid_d  = 1'b0;
                addr_d        = nxt(addr_q, start_q, end_q);
                rom_address_d = nxt(nxt(addr_q, start_q, end_q), start_q, end_q);
                pipe_issue    = 1'b1;
              end else begin
                cur_valid_d = 1'b0;
              end
            end else begin
              rep_d = rep_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_q       <= '0;
      end_q         <= '0;
      loop_q        <= 1'b0;
      addr_q        <= '0;
      rom_address_q <= '0;
      cur_q         <= '0;
      cur_valid_q   <= 1'b0;
      next_q        <= '0;
      next_valid_q  <= 1'b0;
      rep_q         <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      end_q         <= end_d;
      loop_q        <= loop_d;
      addr_q        <= addr_d;
      rom_address_q <= rom_address_d;
      cur_q         <= cur_d;
      cur_valid_q   <= cur_valid_d;
      next_q        <= next_d;
      next_valid_q  <= next_valid_d;
      rep_q         <= rep_d;
    end
  end

endmodule

// File: tb/tb_sfx_sample_player.sv
// Scoreboard bench for sfx_sample_player: expected codec writes are queued
// when a clip is started and compared at each observed write strobe.
module tb_sfx_sample_player;

  logic        clk = 1'b0;
  logic        reset, play, stop, loop_i, allowed;
  logic [15:0] clip_start, clip_end, rom_address, rom_data;
  logic        write_o, busy, done;
  logic [31:0] left_o, right_o;

  logic [15:0] mem [0:255];

  typedef struct {
    logic [31:0] d;
    logic        dn;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_bad   = 0;
  int wr_cnt  = 0;
  bit mon_en  = 1'b0;
  bit gap_chk = 1'b0;

  always #5 clk = ~clk;

  // ROM_LATENCY = 1: data for the address registered at one edge is sampled at the next.
  assign rom_data = mem[rom_address[7:0]];

  sfx_sample_player #(
    .ADDR_W(16), .DATA_W(16), .REPEAT(6), .ROM_LATENCY(1), .GAIN_SHIFT(14)
  ) dut (
    .CLOCK_50                (clk),
    .reset                   (reset),
    .play                    (play),
    .stop                    (stop),
    .loop                    (loop_i),
    .clip_start              (clip_start),
    .clip_end                (clip_end),
    .rom_address             (rom_address),
    .rom_data                (rom_data),
    .audio_out_allowed       (allowed),
    .write_audio_out         (write_o),
    .left_channel_audio_out  (left_o),
    .right_channel_audio_out (right_o),
    .busy                    (busy),
    .done                    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] scale(input logic [15:0] s);
    logic [31:0] e;
    e = {{16{s[15]}}, s};
    return e << 14;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (!allowed) chk("wr_when_blocked", {31'd0, write_o}, 32'd0);
      if (gap_chk && q.size() > 0) chk("gap", {31'd0, write_o}, 32'd1);
      if (write_o) begin
        wr_cnt++;
        if (q.size() > 0) e = q.pop_front();
        else e = '{d: 32'd0, dn: 1'b0};
        chk("left", left_o, e.d);
        chk("right", right_o, e.d);
        chk("done", {31'd0, done}, {31'd0, e.dn});
      end else begin
        chk("done_no_wr", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic push_seq(input int s, input int e, input int n_samp, input bit dn_end);
    int a = s;
    for (int k = 0; k < n_samp; k++) begin
      for (int r = 0; r < 6; r++)
        q.push_back('{d: scale(mem[a]), dn: dn_end && k == n_samp - 1 && r == 5});
      a = (a == e) ? s : a + 1;
    end
  endtask

  task automatic trim(input int n);
    while (q.size() > n) void'(q.pop_back());
  endtask

  task automatic play_clip(input int s, input int e, input bit lp);
    clip_start = 16'(s);
    clip_end   = 16'(e);
    loop_i     = lp;
    play       = 1'b1;
    @(posedge clk); #1;
    play   = 1'b0;
    q.delete();
    wr_cnt = 0;
    @(negedge clk);
    chk("load_no_wr", {31'd0, write_o}, 32'd0);
    chk("load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int max_cyc, input bit rnd);
    int b = 0;
    while (q.size() > 0 && b < max_cyc) begin
      if (rnd) allowed = ($urandom_range(0, 9) < 3);
      @(posedge clk); #1;
      b++;
    end
    allowed = 1'b1;
    if (q.size() > 0) chk("timeout_drain", 32'd1, 32'd0);
  endtask

  task automatic wait_wr(input int n, input int max_cyc);
    int b = 0;
    while (wr_cnt < n && b < max_cyc) begin
      @(posedge clk); #1;
      b++;
    end
    if (wr_cnt < n) chk("timeout_writes", 32'(wr_cnt), 32'(n));
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop    = 1'b0;
    gap_chk = 1'b0;
  endtask

  task automatic settle_idle(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, {31'd0, busy}, 32'd0);
    chk({tag, "_q"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[10] = 16'h0001; mem[11] = 16'h7FFF; mem[12] = 16'hFFFF;
    mem[20] = 16'h1234; mem[21] = 16'h8000;
    mem[30] = 16'h0100; mem[31] = 16'hFF00;
    mem[40] = 16'hC000;

    reset = 1'b1; play = 1'b0; stop = 1'b0; loop_i = 1'b0; allowed = 1'b1;
    clip_start = '0; clip_end = '0;
    #2;
    chk("rst_write", {31'd0, write_o}, 32'd0);
    chk("rst_left", left_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, rom_address}, 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle silence.
    wr_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_writes", 32'(wr_cnt), 32'd20);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Basic 3-sample clip.
    play_clip(10, 12, 1'b0);
    push_seq(10, 12, 3, 1'b1);
    gap_chk = 1'b1;
    wait_empty(200, 1'b0);
    gap_chk = 1'b0;
    settle_idle("basic_end");

    // Same clip under random back-pressure.
    play_clip(10, 12, 1'b0);
    push_seq(10, 12, 3, 1'b1);
    wait_empty(2000, 1'b1);
    settle_idle("rand_end");

    // Looping two-sample clip across five wraps, then stop.
    play_clip(30, 31, 1'b1);
    push_seq(30, 31, 11, 1'b0);
    trim(61);
    gap_chk = 1'b1;
    wait_wr(60, 400);
    pulse_stop();
    settle_idle("loop_stop");

    // Stop on the 4th write of sample 2.
    play_clip(10, 12, 1'b0);
    push_seq(10, 12, 3, 1'b1);
    trim(10);
    gap_chk = 1'b1;
    wait_wr(9, 200);
    pulse_stop();
    settle_idle("stop_mid");

    // Play and stop together from idle.
    clip_start = 16'd10; clip_end = 16'd12; loop_i = 1'b0;
    play = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    play = 1'b0; stop = 1'b0;
    chk("play_stop_busy", {31'd0, busy}, 32'd0);
    settle_idle("play_stop");

    // Reversed bounds are ignored.
    clip_start = 16'd12; clip_end = 16'd10;
    play = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
    chk("bad_bounds_busy", {31'd0, busy}, 32'd0);

    // Single-sample clip.
    play_clip(40, 40, 1'b0);
    push_seq(40, 40, 1, 1'b1);
    gap_chk = 1'b1;
    wait_empty(100, 1'b0);
    gap_chk = 1'b0;
    settle_idle("single_end");

    // Retrigger during playback.
    play_clip(10, 12, 1'b0);
    push_seq(10, 12, 3, 1'b1);
    wait_wr(3, 100);
    play_clip(20, 21, 1'b0);
    push_seq(20, 21, 2, 1'b1);
    gap_chk = 1'b1;
    wait_empty(200, 1'b0);
    gap_chk = 1'b0;
    settle_idle("retrig_end");

    // Asynchronous reset in the middle of PLAY.
    play_clip(10, 12, 1'b0);
    push_seq(10, 12, 3, 1'b1);
    wait_wr(8, 100);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", {31'd0, write_o}, 32'd0);
    chk("mid_rst_left", left_o, 32'd0);
    chk("mid_rst_right", right_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_addr", {16'd0, rom_address}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    settle_idle("after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
